// File: rtl/yarvi_bus_arb.sv
// rtl/yarvi_bus_arb.sv - two-requester memory bus arbiter, data priority with fetch starvation guard
module yarvi_bus_arb #(
    parameter int VMSB         = 31,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          restart,

    input  logic          i_req,
    input  logic [VMSB:0] i_addr,
    output logic          i_gnt,
    output logic          i_done,
    output logic [63:0]   i_rdata,

    input  logic          d_req,
    input  logic [VMSB:0] d_addr,
    input  logic          d_we,
    input  logic [7:0]    d_wmask,
    input  logic [63:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [63:0]   d_rdata,

    output logic          bus_req,
    output logic [VMSB:0] bus_addr,
    output logic          bus_we,
    output logic [7:0]    bus_wmask,
    output logic [63:0]   bus_wdata,
    input  logic          bus_ack,
    input  logic [63:0]   bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic       drop;
    logic [3:0] starve_cnt;
    logic       starve;

    assign starve = (starve_cnt == LIMIT) && i_req;

    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (!reset && state == IDLE) begin
            d_gnt = d_req && !starve;
            i_gnt = i_req && !d_gnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            drop       <= 1'b0;
            starve_cnt <= '0;
            bus_req    <= 1'b0;
            bus_addr   <= '0;
            bus_we     <= 1'b0;
            bus_wmask  <= '0;
            bus_wdata  <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!i_req)
                        starve_cnt <= '0;
                    if (d_gnt) begin
                        state     <= BUS_D;
                        bus_req   <= 1'b1;
                        bus_addr  <= d_addr;
                        bus_we    <= d_we;
                        bus_wmask <= d_wmask;
                        bus_wdata <= d_wdata;
                        if (i_req && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (i_gnt) begin
                        state      <= BUS_I;
                        bus_req    <= 1'b1;
                        bus_addr   <= i_addr;
                        bus_we     <= 1'b0;
                        bus_wmask  <= '0;
                        starve_cnt <= '0;
                        drop       <= restart;
                    end
                end
                BUS_I: begin
                    if (bus_ack) begin
                        // a restart on the ack cycle itself also kills the result
                        if (!(drop || restart)) begin
                            i_rdata <= bus_rdata;
                            i_done  <= 1'b1;
                        end
                        drop    <= 1'b0;
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end else if (restart) begin
                        drop <= 1'b1;
                    end
                end
                BUS_D: begin
                    if (bus_ack) begin
                        if (!bus_we)
                            d_rdata <= bus_rdata;
                        d_done  <= 1'b1;
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yarvi_bus_arb.sv
// tb/tb_yarvi_bus_arb.sv - self-checking bench for yarvi_bus_arb
module tb_yarvi_bus_arb;
    localparam int VMSB  = 31;
    localparam int LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset, restart;
    logic          i_req, i_gnt, i_done;
    logic [VMSB:0] i_addr;
    logic [63:0]   i_rdata;
    logic          d_req, d_we, d_gnt, d_done;
    logic [VMSB:0] d_addr;
    logic [7:0]    d_wmask;
    logic [63:0]   d_wdata, d_rdata;
    logic          bus_req, bus_we, bus_ack;
    logic [VMSB:0] bus_addr;
    logic [7:0]    bus_wmask;
    logic [63:0]   bus_wdata, bus_rdata;

    yarvi_bus_arb #(.VMSB(VMSB), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset), .restart(restart),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wmask(bus_wmask),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [VMSB:0] act, input logic [VMSB:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the bus, whether the fetch result is stale,
    // and how many data grants fetch has watched go by while waiting.
    int            owner;      // 0 none, 1 fetch, 2 data
    bit            stale;
    int            d_streak;
    logic [63:0]   m_irdata, m_drdata, m_wdata;
    logic [VMSB:0] m_addr;
    logic          m_we, m_idone, m_ddone;
    logic [7:0]    m_mask;
    logic          last_ig, last_dg;

    task automatic model_reset();
        owner = 0; stale = 0; d_streak = 0;
        m_irdata = '0; m_drdata = '0; m_wdata = '0; m_addr = '0;
        m_we = 1'b0; m_mask = '0; m_idone = 1'b0; m_ddone = 1'b0;
    endtask

    task automatic check_cycle();
        logic fetch_due, eg_d, eg_i;
        fetch_due = i_req && (d_streak >= LIMIT);
        eg_d = (owner == 0) && d_req && !fetch_due;
        eg_i = (owner == 0) && i_req && !eg_d;
        chkb("d_gnt", d_gnt, eg_d);
        chkb("i_gnt", i_gnt, eg_i);
        chkb("bus_req", bus_req, owner != 0);
        chkb("i_done", i_done, m_idone);
        chkb("d_done", d_done, m_ddone);
        chkd("i_rdata", i_rdata, m_irdata);
        chkd("d_rdata", d_rdata, m_drdata);
        if (owner != 0) begin
            chka("bus_addr", bus_addr, m_addr);
            chkb("bus_we", bus_we, m_we);
            chkd("bus_wmask", {56'b0, bus_wmask}, {56'b0, m_mask});
            if (owner == 2) chkd("bus_wdata", bus_wdata, m_wdata);
        end
        m_idone = 1'b0;
        m_ddone = 1'b0;
        if (owner == 0) begin
            if (!i_req) d_streak = 0;
            if (eg_d) begin
                owner = 2; m_addr = d_addr; m_we = d_we; m_mask = d_wmask; m_wdata = d_wdata;
                if (i_req) d_streak++;
            end else if (eg_i) begin
                owner = 1; m_addr = i_addr; m_we = 1'b0; m_mask = '0;
                stale = restart; d_streak = 0;
            end
        end else begin
            if (owner == 1 && restart) stale = 1;
            if (bus_ack) begin
                if (owner == 1 && !stale) begin m_irdata = bus_rdata; m_idone = 1'b1; end
                if (owner == 2) begin m_ddone = 1'b1; if (!m_we) m_drdata = bus_rdata; end
                owner = 0;
                stale = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_cycle();
        last_ig = i_gnt;
        last_dg = d_gnt;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit ir, dr, rs, ack;
        bit eig, edg, ebr, eid, edd;
    } vec_t;

    vec_t tbl[9];
    bit   got_i[10];
    bit   exp_i[10];
    int   ng;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1,1,0,0, 0,1,0,0,0};
        tbl[1] = '{1,0,0,1, 0,0,1,0,0};
        tbl[2] = '{1,0,0,0, 1,0,0,0,1};
        tbl[3] = '{0,0,0,0, 0,0,1,0,0};
        tbl[4] = '{0,0,0,1, 0,0,1,0,0};
        tbl[5] = '{0,0,0,0, 0,0,0,1,0};
        tbl[6] = '{1,0,1,0, 1,0,0,0,0};
        tbl[7] = '{0,0,0,1, 0,0,1,0,0};
        tbl[8] = '{0,0,0,0, 0,0,0,0,0};
        exp_i = '{0,0,0,0,1,0,0,0,0,1};

        reset = 1'b1; restart = 1'b0; i_req = 1'b1; d_req = 1'b1;
        i_addr = '0; d_addr = '0; d_we = 1'b0; d_wmask = '0; d_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        last_ig = 1'b0; last_dg = 1'b0;
        model_reset();
        #12;
        chkb("rst_d_gnt", d_gnt, 1'b0);
        chkb("rst_i_gnt", i_gnt, 1'b0);
        chkb("rst_bus_req", bus_req, 1'b0);
        chkb("rst_done", i_done | d_done, 1'b0);
        chkd("rst_rdata", i_rdata | d_rdata, 64'h0);
        @(posedge clock); #1;
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        step();

        // Table: simultaneous requests, fetch after data, restart in grant cycle
        i_addr = 32'h40; d_addr = 32'h80; bus_rdata = 64'hCAFE_0000_0000_0001;
        for (int k = 0; k < 9; k++) begin
            i_req = tbl[k].ir; d_req = tbl[k].dr; restart = tbl[k].rs; bus_ack = tbl[k].ack;
            #1;
            chkb($sformatf("tbl%0d_i_gnt", k), i_gnt, tbl[k].eig);
            chkb($sformatf("tbl%0d_d_gnt", k), d_gnt, tbl[k].edg);
            chkb($sformatf("tbl%0d_bus_req", k), bus_req, tbl[k].ebr);
            chkb($sformatf("tbl%0d_i_done", k), i_done, tbl[k].eid);
            chkb($sformatf("tbl%0d_d_done", k), d_done, tbl[k].edd);
            step();
        end
        restart = 1'b0; bus_ack = 1'b0;

        // Single load, zero wait
        d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; #1;
        chkb("load_gnt", d_gnt, 1'b1);
        step();
        d_req = 1'b0; bus_ack = 1'b1; bus_rdata = 64'hDEADBEEF; #1;
        chkb("load_bus_req", bus_req, 1'b1);
        chka("load_bus_addr", bus_addr, 32'h100);
        step();
        bus_ack = 1'b0; #1;
        chkb("load_done", d_done, 1'b1);
        chkd("load_rdata", d_rdata, 64'hDEADBEEF);
        chkb("load_bus_idle", bus_req, 1'b0);
        step();

        // Store with three-cycle bus wait
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wmask = 8'h0F; d_wdata = 64'h1122334455667788; #1;
        chkb("store_gnt", d_gnt, 1'b1);
        step();
        d_req = 1'b0; d_we = 1'b0; d_wmask = '0; d_wdata = '0;
        for (int c = 1; c <= 3; c++) begin
            bus_ack = (c == 3); bus_rdata = 64'h5555; #1;
            chka("store_addr", bus_addr, 32'h300);
            chkb("store_we", bus_we, 1'b1);
            chkd("store_wmask", {56'b0, bus_wmask}, 64'h0F);
            chkd("store_wdata", bus_wdata, 64'h1122334455667788);
            step();
        end
        bus_ack = 1'b0; #1;
        chkb("store_done", d_done, 1'b1);
        chkd("store_rdata_kept", d_rdata, 64'hDEADBEEF);
        step();

        // Starvation guard, zero-wait bus
        bus_rdata = 64'hCAFE_0000_0000_0001;
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h180; i_addr = 32'h1C0; ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            bus_ack = bus_req; #1;
            if (i_gnt || d_gnt) begin got_i[ng] = i_gnt; ng++; end
            step();
        end
        chkd("starve_grant_count", 64'(ng), 64'd10);
        for (int k = 0; k < 10; k++) chkb($sformatf("starve_seq%0d_is_fetch", k), got_i[k], exp_i[k]);
        i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 3; c++) begin bus_ack = bus_req; step(); end
        bus_ack = 1'b0;

        // Restart two cycles into a long fetch
        i_req = 1'b1; i_addr = 32'h200; bus_rdata = 64'h0BAD; #1;
        chkb("rs_gnt", i_gnt, 1'b1);
        step();
        i_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            restart = (c == 2); bus_ack = (c == 6); #1;
            chkb("rs_bus_req_held", bus_req, 1'b1);
            step();
        end
        restart = 1'b0; bus_ack = 1'b0; #1;
        chkb("rs_no_done", i_done, 1'b0);
        chkd("rs_rdata_kept", i_rdata, 64'hCAFE_0000_0000_0001);
        step();
        i_req = 1'b1; i_addr = 32'h240; bus_rdata = 64'h1234; #1;
        chkb("rs_next_gnt", i_gnt, 1'b1);
        step();
        i_req = 1'b0; bus_ack = 1'b1;
        step();
        bus_ack = 1'b0; #1;
        chkb("rs_next_done", i_done, 1'b1);
        chkd("rs_next_rdata", i_rdata, 64'h1234);
        step();

        // Randomised traffic against the model
        for (int c = 0; c < 2000; c++) begin
            if (i_req && last_ig) i_req = 1'b0;
            else if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
            if (d_req && last_dg) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom);
                d_wmask = 8'($urandom); d_wdata = {$urandom, $urandom};
            end
            restart = ($urandom_range(0, 7) == 0);
            bus_ack = bus_req && ($urandom_range(0, 2) == 0);
            bus_rdata = {$urandom, $urandom};
            step();
        end
        i_req = 1'b0; d_req = 1'b0; restart = 1'b0;
        for (int c = 0; c < 4; c++) begin bus_ack = bus_req; step(); end

        // Asynchronous reset in the middle of a data transaction
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; bus_ack = 1'b0;
        step();
        d_req = 1'b0;
        step();
        d_req = 1'b1; #2;
        reset = 1'b1; #1;
        chkb("areset_bus_req", bus_req, 1'b0);
        chkb("areset_d_gnt", d_gnt, 1'b0);
        chkb("areset_i_gnt", i_gnt, 1'b0);
        chka("areset_bus_addr", bus_addr, 32'h0);
        chkb("areset_bus_we", bus_we, 1'b0);
        chkd("areset_bus_wmask", {56'b0, bus_wmask}, 64'h0);
        chkd("areset_bus_wdata", bus_wdata, 64'h0);
        chkd("areset_i_rdata", i_rdata, 64'h0);
        chkd("areset_d_rdata", d_rdata, 64'h0);
        repeat (2) @(posedge clock);
        #1;
        d_req = 1'b0; reset = 1'b0; model_reset();
        bus_ack = 1'b1; bus_rdata = 64'h77;
        step();
        bus_ack = 1'b0;
        chkb("areset_no_done", d_done, 1'b0);
        chkd("areset_rdata_after", d_rdata, 64'h0);
        step();
        chkb("areset_no_done_late", d_done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/yarvi_bus_arb.md
# yarvi_bus_arb

Two-requester arbiter that shares one external memory bus between the fetch stage (instruction refill) and the memory stage (data loads/stores). It serialises at most one outstanding bus transaction, gives data priority over fetch with a starvation guard, and discards fetch results made stale by a pipeline restart. It sits between `yarvi_fe`/`yarvi_me` and the single off-core memory port.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch is waiting; the next grant then goes to fetch (range 1–15).
- `clock`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `restart`  in  1  pipeline restart (from ex); invalidates the fetch access that is granted or in flight.
- `i_req`  in  1  fetch request; held until `i_gnt`.
- `i_addr`  in  `VMSB`+1  fetch address; fetch is always a read.
- `i_gnt`  out  1  fetch request accepted (combinational, IDLE only).
- `i_done`  out  1  one-cycle pulse: fetch data valid.
- `i_rdata`  out  64  fetch read data, valid with `i_done`.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_addr`  in  `VMSB`+1  data address.
- `d_we`  in  1  1 = store, 0 = load.
- `d_wmask`  in  8  byte enables for stores.
- `d_wdata`  in  64  store data.
- `d_gnt`  out  1  data request accepted (combinational, IDLE only).
- `d_done`  out  1  one-cycle pulse: load data valid or store complete.
- `d_rdata`  out  64  load data, valid with `d_done`. Undefined-but-stable for stores: it holds the last value.
- `bus_req`  out  1  bus transaction active; held until `bus_ack`.
- `bus_addr`, `bus_we`, `bus_wmask`, `bus_wdata`  out  `VMSB`+1/1/8/64  registered transaction fields, stable while `bus_req`.
- `bus_ack`  in  1  one-cycle completion; `bus_rdata` valid in the same cycle.
- `bus_rdata`  in  64  read data.

## Operation
- State machine with three states: IDLE, BUS_I, BUS_D.
- IDLE arbitration:
  - If `d_req` is set and the starvation condition is not met, grant data: `d_gnt` = 1, go to BUS_D.
  - Otherwise, if `i_req` is set, grant fetch: `i_gnt` = 1, go to BUS_I.
  - Only one grant is issued per cycle.
- Starvation condition: `starve_cnt` == `STARVE_LIMIT` and `i_req` = 1.
- Starvation counter (4 bits):
  - Increments on each data grant made while `i_req` = 1, saturating at `STARVE_LIMIT`.
  - Clears on a fetch grant, and in any IDLE cycle with `i_req` = 0.
- On grant, the winner's fields are registered into `bus_*`. `bus_we` = 0 and `bus_wmask` = 0 for fetch. `bus_req` = 1 from the next cycle.
- BUS_x: hold `bus_req` and the fields until `bus_ack`. On `bus_ack`:
  - Capture `bus_rdata` into the winner's rdata register.
  - Assert the winner's done on the next cycle.
  - Clear `bus_req`, return to IDLE.
- `bus_ack` is ignored in IDLE.
- Restart / drop flag:
  - `restart` in the fetch grant cycle, or at any point in BUS_I (including the `bus_ack` cycle), sets `drop`.
  - The bus transaction still completes.
  - On its ack, `i_done` is suppressed and `i_rdata` is not updated.
  - `drop` clears on return to IDLE.
  - `restart` does not affect data transactions.
- Reset (asynchronous, also mid-transaction):
  - State goes to IDLE.
  - `bus_req`, `i_done`, `d_done`, `drop`, `starve_cnt` = 0.
  - `bus_addr`, `bus_wmask`, `bus_wdata`, `i_rdata`, `d_rdata` = 0; `bus_we` = 0.
  - The in-flight transaction is abandoned and no done is produced.
  - `i_gnt` and `d_gnt` = 0 while `reset` is high.

## Timing
- Cycle 0: request seen in IDLE, gnt = 1.
- Cycle 1: `bus_req` = 1.
- Cycle k ≥ 1: `bus_ack`.
- Cycle k+1: done = 1, state = IDLE, and a new grant is possible in the same cycle.
- Minimum request→done latency is 2 cycles. Peak throughput is one transaction per 2 cycles with a zero-wait bus.
- Grants are never issued in BUS_I/BUS_D, regardless of requests.

## Test plan
- Single load: `d_req` with addr 0x100, we = 0 in IDLE; `bus_ack` 1 cycle later with rdata 0xDEADBEEF → `d_gnt` at cycle 0, `bus_req` at cycle 1, `d_done` + `d_rdata` = 0xDEADBEEF at cycle 2.
- Simultaneous requests: `i_req` and `d_req` in the same cycle → data granted first, fetch granted in the IDLE cycle after `d_done`.
- Starvation: `d_req` held continuously, `i_req` held, `STARVE_LIMIT` = 4 → grants D,D,D,D,I,D…; `starve_cnt` clears after the I grant.
- Restart mid-fetch: fetch granted, `restart` pulsed 2 cycles into a 5-cycle wait → `bus_req` held until ack, no `i_done`, `i_rdata` unchanged; the next fetch completes normally.
- Store with wait states: `d_we` = 1, wmask 0x0F, wdata 0x1122334455667788, ack after 3 cycles → bus fields stable for 3 cycles, `d_done` at cycle 4, `d_rdata` unchanged.
- Async reset during BUS_D → `bus_req` drops in the same cycle with no clock edge needed; all outputs are 0 and no done is produced after reset release.
